// File: rtl/pid_sched_pkg.sv
// Shared widths, state encoding and gain payload for the BLDC velocity-loop scheduler.
package pid_sched_pkg;

    localparam int unsigned VEL_W  = 8;
    localparam int unsigned GAIN_W = 4;
    localparam int unsigned DUTY_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        CAPTURE,
        STEP,
        SETTLE,
        APPLY
    } state_e;

    typedef struct packed {
        logic [GAIN_W-1:0] kp;
        logic [GAIN_W-1:0] kd;
    } gains_t;

endpackage

// File: rtl/duty_slew_limiter.sv
// Clamps the PID target into [min,max] and limits the step from the previous duty.
module duty_slew_limiter
    import pid_sched_pkg::*;
(
    input  logic [VEL_W-1:0]  target_i,
    input  logic [DUTY_W-1:0] prev_i,
    input  logic [DUTY_W-1:0] duty_min_i,
    input  logic [DUTY_W-1:0] duty_max_i,
    input  logic [DUTY_W-1:0] slew_max_i,
    output logic [DUTY_W-1:0] next_duty_c
);

    logic [DUTY_W-1:0]      clamped;
    logic signed [DUTY_W:0] diff;
    logic signed [DUTY_W:0] slew;

    always_comb begin
        clamped = DUTY_W'(target_i);
        if (DUTY_W'(target_i) < duty_min_i) begin
            clamped = duty_min_i;
        end else if (DUTY_W'(target_i) > duty_max_i) begin
            clamped = duty_max_i;
        end
        // Both operands are unsigned 8-bit, so a 9-bit signed difference cannot overflow.
        diff = $signed({1'b0, clamped}) - $signed({1'b0, prev_i});
        slew = $signed({1'b0, slew_max_i});
        if (diff > slew) begin
            next_duty_c = prev_i + slew_max_i;
        end else if (diff < -slew) begin
            next_duty_c = prev_i - slew_max_i;
        end else begin
            next_duty_c = clamped;
        end
    end

endmodule

// File: rtl/pid_loop_scheduler.sv
// Sequences one velocity-loop sample around an external PID: tick, capture, step, settle, apply.
module pid_loop_scheduler
    import pid_sched_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 1000,
    parameter int unsigned PID_LATENCY   = 2,
    parameter int unsigned DUTY_MIN      = 0,
    parameter int unsigned DUTY_MAX      = 250,
    parameter int unsigned SLEW_MAX      = 16,
    parameter int unsigned KP_INIT       = 4,
    parameter int unsigned KD_INIT       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fault_in,
    input  logic [VEL_W-1:0]  vel_meas,
    input  logic              vel_meas_valid,
    input  logic [GAIN_W-1:0] gain_kp_in,
    input  logic [GAIN_W-1:0] gain_kd_in,
    input  logic              gain_wr_valid,
    output logic              gain_wr_ready,
    output logic [VEL_W-1:0]  pid_current_vel,
    output logic [GAIN_W-1:0] pid_kp,
    output logic [GAIN_W-1:0] pid_kd,
    output logic              pid_ce,
    input  logic [VEL_W-1:0]  pid_vel_output,
    output logic [DUTY_W-1:0] duty_cmd,
    output logic              duty_valid,
    output logic              stale_meas,
    output logic              fault_latched,
    output logic              busy
);

    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int unsigned LAT_W = $clog2(PID_LATENCY + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [VEL_W-1:0]  meas_q, meas_d, vel_q, vel_d;
    logic [DUTY_W-1:0] duty_q, duty_d, duty_next_c;
    gains_t            gains_q, gains_d, pend_q, pend_d;
    logic              fresh_q, fresh_d, pending_q, pending_d, ready_q, ready_d;
    logic              ce_q, ce_d, dv_q, dv_d, stale_q, stale_d;
    logic              flt_q, flt_d, busy_q, busy_d;
    logic              tick;

    assign tick = (cnt_q == CNT_W'(PERIOD_CYCLES - 1));

    duty_slew_limiter u_limiter (
        .target_i    (pid_vel_output),
        .prev_i      (duty_q),
        .duty_min_i  (DUTY_W'(DUTY_MIN)),
        .duty_max_i  (DUTY_W'(DUTY_MAX)),
        .slew_max_i  (DUTY_W'(SLEW_MAX)),
        .next_duty_c (duty_next_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        meas_d    = meas_q;
        vel_d     = vel_q;
        duty_d    = duty_q;
        gains_d   = gains_q;
        pend_d    = pend_q;
        fresh_d   = fresh_q;
        pending_d = pending_q;
        stale_d   = stale_q;
        flt_d     = flt_q;
        ce_d      = 1'b0;
        dv_d      = 1'b0;

        if (vel_meas_valid && (state_q != CAPTURE)) begin
            meas_d  = vel_meas;
            fresh_d = 1'b1;
        end
        if (gain_wr_valid && !pending_q) begin
            pend_d    = '{kp: gain_kp_in, kd: gain_kd_in};
            pending_d = 1'b1;
        end

        if (enable && !flt_q) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (enable && !flt_q) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (tick) state_d = CAPTURE;
            end
            CAPTURE: begin
                vel_d   = vel_meas_valid ? vel_meas : meas_q;
                stale_d = !(fresh_q || vel_meas_valid);
                fresh_d = 1'b0;
                // Only gains pending before this cycle are applied; a same-cycle write waits.
                if (pending_q) begin
                    gains_d   = pend_q;
                    pending_d = 1'b0;
                end
                ce_d    = 1'b1;
                state_d = STEP;
            end
            STEP: begin
                lat_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (lat_q == LAT_W'(PID_LATENCY - 1)) begin
                    duty_d  = duty_next_c;
                    dv_d    = 1'b1;
                    state_d = APPLY;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            APPLY: begin
                state_d = WAIT_TICK;
            end
            default: state_d = IDLE;
        endcase

        // Fault dominates disable; both abandon the sample without pulses.
        if (fault_in) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
            ce_d    = 1'b0;
            dv_d    = 1'b0;
            flt_d   = 1'b1;
        end else if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
            ce_d    = 1'b0;
            dv_d    = 1'b0;
            flt_d   = 1'b0;
        end

        ready_d = !pending_d;
        busy_d  = (state_d == CAPTURE) || (state_d == STEP) ||
                  (state_d == SETTLE)  || (state_d == APPLY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_q     <= '0;
            meas_q    <= '0;
            vel_q     <= '0;
            duty_q    <= '0;
            gains_q   <= '{kp: GAIN_W'(KP_INIT), kd: GAIN_W'(KD_INIT)};
            pend_q    <= '0;
            fresh_q   <= 1'b0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            stale_q   <= 1'b0;
            flt_q     <= 1'b0;
            ce_q      <= 1'b0;
            dv_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            meas_q    <= meas_d;
            vel_q     <= vel_d;
            duty_q    <= duty_d;
            gains_q   <= gains_d;
            pend_q    <= pend_d;
            fresh_q   <= fresh_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            stale_q   <= stale_d;
            flt_q     <= flt_d;
            ce_q      <= ce_d;
            dv_q      <= dv_d;
            busy_q    <= busy_d;
        end
    end

    assign gain_wr_ready   = ready_q;
    assign pid_current_vel = vel_q;
    assign pid_kp          = gains_q.kp;
    assign pid_kd          = gains_q.kd;
    assign pid_ce          = ce_q;
    assign duty_cmd        = duty_q;
    assign duty_valid      = dv_q;
    assign stale_meas      = stale_q;
    assign fault_latched   = flt_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Directed bench for pid_loop_scheduler with an 8-cycle sample period.
module tb_pid_loop_scheduler;

    logic       clk = 1'b0;
    logic       rst, enable, fault_in, vel_meas_valid, gain_wr_valid;
    logic [7:0] vel_meas, pid_vel_output;
    logic [3:0] gain_kp_in, gain_kd_in;
    logic       gain_wr_ready, pid_ce, duty_valid, stale_meas, fault_latched, busy;
    logic [7:0] pid_current_vel, duty_cmd;
    logic [3:0] pid_kp, pid_kd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_ce, n_dv;

    always #5 clk = ~clk;

    pid_loop_scheduler #(
        .PERIOD_CYCLES (8),
        .PID_LATENCY   (2),
        .DUTY_MIN      (0),
        .DUTY_MAX      (250),
        .SLEW_MAX      (16),
        .KP_INIT       (4),
        .KD_INIT       (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .fault_in        (fault_in),
        .vel_meas        (vel_meas),
        .vel_meas_valid  (vel_meas_valid),
        .gain_kp_in      (gain_kp_in),
        .gain_kd_in      (gain_kd_in),
        .gain_wr_valid   (gain_wr_valid),
        .gain_wr_ready   (gain_wr_ready),
        .pid_current_vel (pid_current_vel),
        .pid_kp          (pid_kp),
        .pid_kd          (pid_kd),
        .pid_ce          (pid_ce),
        .pid_vel_output  (pid_vel_output),
        .duty_cmd        (duty_cmd),
        .duty_valid      (duty_valid),
        .stale_meas      (stale_meas),
        .fault_latched   (fault_latched),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ce(input string tag);
        int n = 0;
        do begin step(); n++; end while (!pid_ce && n < 40);
        check({tag, "_ce_seen"}, 32'(pid_ce), 1);
    endtask

    task automatic wait_dv(input string tag);
        int n = 0;
        do begin step(); n++; end while (!duty_valid && n < 40);
        check({tag, "_dv_seen"}, 32'(duty_valid), 1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin step(); n++; end while (!gain_wr_ready && n < 40);
        check({tag, "_ready_seen"}, 32'(gain_wr_ready), 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; fault_in = 1'b0;
        vel_meas = 8'd0; vel_meas_valid = 1'b0;
        gain_kp_in = 4'd0; gain_kd_in = 4'd0; gain_wr_valid = 1'b0;
        pid_vel_output = 8'd200;
        repeat (3) step();

        // Reset values
        check("rst_duty", 32'(duty_cmd), 0);
        check("rst_dv", 32'(duty_valid), 0);
        check("rst_ce", 32'(pid_ce), 0);
        check("rst_kp", 32'(pid_kp), 4);
        check("rst_kd", 32'(pid_kd), 1);
        check("rst_ready", 32'(gain_wr_ready), 1);
        check("rst_stale", 32'(stale_meas), 0);
        check("rst_fault", 32'(fault_latched), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_vel", 32'(pid_current_vel), 0);

        // Timing: tick on 8th enabled cycle, ce at T+2, duty_valid at T+5, period 8
        rst = 1'b0; enable = 1'b1; cyc = 0;
        wait_ce("t1");
        check("t1_ce_cycle", 32'(cyc), 9);
        check("t1_busy", 32'(busy), 1);
        check("t1_stale_first", 32'(stale_meas), 1);
        check("t1_vel_first", 32'(pid_current_vel), 0);
        step();
        check("t1_ce_one_cycle", 32'(pid_ce), 0);
        wait_dv("t1a");
        check("t1_dv_cycle", 32'(cyc), 12);
        check("t2_duty_1", 32'(duty_cmd), 16);
        wait_dv("t1b");
        check("t1_dv_period", 32'(cyc), 20);
        check("t2_duty_2", 32'(duty_cmd), 32);

        // Slew ramp toward 200
        for (int k = 3; k <= 14; k++) begin
            wait_dv("t2");
            check($sformatf("t2_duty_%0d", k), 32'(duty_cmd), (16 * k < 200) ? 16 * k : 200);
        end

        // Saturation at DUTY_MAX, then ramp down to 0
        pid_vel_output = 8'd255;
        for (int k = 1; k <= 5; k++) begin
            wait_dv("t3up");
            check($sformatf("t3_up_%0d", k), 32'(duty_cmd),
                  (200 + 16 * k < 250) ? 200 + 16 * k : 250);
        end
        pid_vel_output = 8'd0;
        for (int k = 1; k <= 17; k++) begin
            wait_dv("t3dn");
            check($sformatf("t3_dn_%0d", k), 32'(duty_cmd), (250 > 16 * k) ? 250 - 16 * k : 0);
        end

        // Gain handshake; a second write stalls while the first is pending
        pid_vel_output = 8'd100;
        gain_kp_in = 4'd5; gain_kd_in = 4'd3; gain_wr_valid = 1'b1;
        step();
        gain_kp_in = 4'd7; gain_kd_in = 4'd9;
        check("t4_ready_low", 32'(gain_wr_ready), 0);
        check("t4_kp_hold", 32'(pid_kp), 4);
        check("t4_kd_hold", 32'(pid_kd), 1);
        wait_ready("t4a");
        check("t4_kp_applied", 32'(pid_kp), 5);
        check("t4_kd_applied", 32'(pid_kd), 3);
        step();
        gain_wr_valid = 1'b0;
        check("t4_second_accepted", 32'(gain_wr_ready), 0);
        check("t4_kp_not_yet", 32'(pid_kp), 5);
        wait_ready("t4b");
        check("t4_kp_second", 32'(pid_kp), 7);
        check("t4_kd_second", 32'(pid_kd), 9);

        // Measurement: last strobe wins, then stale with no strobe
        vel_meas = 8'd40; vel_meas_valid = 1'b1;
        step();
        vel_meas = 8'd60;
        step();
        vel_meas_valid = 1'b0; vel_meas = 8'd0;
        wait_ce("t5a");
        check("t5_vel_last", 32'(pid_current_vel), 60);
        check("t5_fresh", 32'(stale_meas), 0);
        wait_ce("t5b");
        check("t5_stale", 32'(stale_meas), 1);
        check("t5_vel_keep", 32'(pid_current_vel), 60);

        // Fault during SETTLE abandons the sample and latches
        step();
        check("t6_duty_nonzero", 32'(duty_cmd != 8'd0), 1);
        fault_in = 1'b1;
        step();
        fault_in = 1'b0;
        check("t6_duty_zero", 32'(duty_cmd), 0);
        check("t6_latched", 32'(fault_latched), 1);
        check("t6_busy", 32'(busy), 0);
        n_ce = 0; n_dv = 0;
        for (int i = 0; i < 12; i++) begin
            n_ce += int'(pid_ce);
            n_dv += int'(duty_valid);
            step();
        end
        check("t6_no_ce", 32'(n_ce), 0);
        check("t6_no_dv", 32'(n_dv), 0);
        check("t6_latched_held", 32'(fault_latched), 1);
        enable = 1'b0;
        step();
        enable = 1'b1; cyc = 0;
        check("t6_latched_clr", 32'(fault_latched), 0);
        wait_ce("t6r");
        check("t6_restart_ce", 32'(cyc), 9);
        wait_dv("t6r");
        check("t6_restart_dv", 32'(cyc), 12);
        check("t6_restart_duty", 32'(duty_cmd), 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
